pixel_proc_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-mode combinational RGB inverter.
- Processes one NCH-channel pixel per cycle behind valid/ready handshakes on input and output.
- Per-pixel operating mode: pass-through, invert, per-channel threshold, or grayscale.
- Sits between a pixel source (camera/frame reader) and a sink (display/DMA writer); also counts delivered pixels.

---
 rtl/pixel_proc_pkg.sv | 30 +++
 rtl/pixel_proc_alu.sv | 44 ++++
 rtl/pixel_proc_pipe.sv | 75 +++++++
 tb/tb_pixel_proc_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_proc_pkg.sv
// Shared types and per-channel arithmetic for the pixel processing pipeline.
package pixel_proc_pkg;

    localparam int MODE_W   = 2;
    // Widest channel the scalar helper supports; callers zero-extend into it.
    localparam int CH_MAX_W = 32;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_THR  = 2'd2,
        MODE_GRAY = 2'd3
    } mode_e;

    // Single-channel result for every mode except GRAY, which needs all channels.
    function automatic logic [CH_MAX_W-1:0] chan_op(
        input logic [CH_MAX_W-1:0] c,
        input logic [CH_MAX_W-1:0] thr,
        input logic [CH_MAX_W-1:0] max_val,
        input mode_e               mode
    );
        chan_op = c;
        case (mode)
            MODE_INV: chan_op = max_val - c;
            MODE_THR: chan_op = (c >= thr) ? max_val : '0;
            default:  chan_op = c;
        endcase
    endfunction

endpackage

// File: rtl/pixel_proc_alu.sv
// Combinational pixel transform: (pixel, mode, threshold) -> pixel.
module pixel_proc_alu
    import pixel_proc_pkg::*;
#(
    parameter int W   = 8,
    parameter int NCH = 3
) (
    input  logic [NCH*W-1:0] pix,
    input  mode_e            mode,
    input  logic [W-1:0]     thr,
    output logic [NCH*W-1:0] res
);

    logic [W-1:0] gray_y;

    generate
        if (NCH == 3) begin : g_gray
            // Two extra bits hold c0 + 2*c1 + c2 without overflow.
            logic [W+1:0] gray_sum;
            assign gray_sum = (W+2)'(pix[0 +: W])
                            + ((W+2)'(pix[W +: W]) << 1)
                            + (W+2)'(pix[2*W +: W]);
            assign gray_y = W'(gray_sum >> 2);
        end else begin : g_no_gray
            $error("pixel_proc_alu: GRAY mode requires NCH == 3");
            assign gray_y = '0;
        end
    endgenerate

    always_comb begin
        res = '0;
        for (int k = 0; k < NCH; k++) begin
            if (mode == MODE_GRAY) begin
                res[k*W +: W] = gray_y;
            end else begin
                res[k*W +: W] = W'(chan_op(CH_MAX_W'(pix[k*W +: W]),
                                           CH_MAX_W'(thr),
                                           CH_MAX_W'({W{1'b1}}),
                                           mode));
            end
        end
    end

endmodule

// File: rtl/pixel_proc_pipe.sv
// Two-stage pixel pipeline with valid/ready on both sides and a delivered-pixel counter.
module pixel_proc_pipe
    import pixel_proc_pkg::*;
#(
    parameter int W     = 8,
    parameter int NCH   = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [NCH*W-1:0]   pix_i,
    input  logic [MODE_W-1:0]  mode_i,
    input  logic [W-1:0]       thr_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [NCH*W-1:0]   pix_o,
    input  logic               cnt_clr_i,
    output logic [CNT_W-1:0]   pix_cnt_o
);

    // Handshake: a beat moves on a side exactly in the cycle where valid and
    // ready are both high; valid_o/pix_o stay frozen while valid_o && !ready_i.
    // ready_o is combinational from ready_i (no skid buffer), capacity 2.
    logic             s1_valid, s2_valid;
    logic             s1_adv, s2_adv;
    logic [NCH*W-1:0] s1_pix, s2_pix, alu_pix;
    mode_e            s1_mode;
    logic [W-1:0]     s1_thr;
    logic [CNT_W-1:0] cnt;

    assign s2_adv    = !s2_valid || ready_i;
    assign s1_adv    = !s1_valid || s2_adv;
    assign ready_o   = s1_adv;
    assign valid_o   = s2_valid;
    assign pix_o     = s2_pix;
    assign pix_cnt_o = cnt;

    pixel_proc_alu #(.W(W), .NCH(NCH)) u_alu (
        .pix  (s1_pix),
        .mode (s1_mode),
        .thr  (s1_thr),
        .res  (alu_pix)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_mode  <= MODE_PASS;
            s1_thr   <= '0;
            s2_valid <= 1'b0;
            s2_pix   <= '0;
            cnt      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= valid_i;
                if (valid_i) begin
                    s1_pix  <= pix_i;
                    s1_mode <= mode_e'(mode_i);
                    s1_thr  <= thr_i;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_pix <= alu_pix;
            end
            // Clear wins over a coincident output transfer.
            if (cnt_clr_i) cnt <= '0;
            else if (s2_valid && ready_i) cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Self-checking bench for pixel_proc_pipe: scenario tasks plus a scoreboard monitor.
module tb_pixel_proc_pipe;

    localparam int W     = 8;
    localparam int NCH   = 3;
    localparam int CNT_W = 4;
    localparam int PW    = NCH * W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_i, ready_o, valid_o, ready_i, cnt_clr_i;
    logic [PW-1:0]    pix_i, pix_o;
    logic [1:0]       mode_i;
    logic [W-1:0]     thr_i;
    logic [CNT_W-1:0] pix_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0]    exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int               occ = 0;
    bit               mon_en = 1'b0;
    bit               hold_chk = 1'b0;
    logic [PW-1:0]    hold_pix = '0;

    always #5 clk = ~clk;

    pixel_proc_pipe #(.W(W), .NCH(NCH), .CNT_W(CNT_W)) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .pix_i     (pix_i),
        .mode_i    (mode_i),
        .thr_i     (thr_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pix_o     (pix_o),
        .cnt_clr_i (cnt_clr_i),
        .pix_cnt_o (pix_cnt_o)
    );

    function automatic logic [PW-1:0] model_pix(input logic [PW-1:0] p, input logic [1:0] m,
                                                input logic [W-1:0] t);
        logic [PW-1:0] r;
        int c;
        int y;
        r = '0;
        y = (int'(p[7:0]) + 2 * int'(p[15:8]) + int'(p[23:16])) / 4;
        for (int k = 0; k < NCH; k++) begin
            c = int'(p[k*W +: W]);
            case (m)
                2'd0: r[k*W +: W] = W'(c);
                2'd1: r[k*W +: W] = W'(255 - c);
                2'd2: r[k*W +: W] = (c >= int'(t)) ? 8'hFF : 8'h00;
                default: r[k*W +: W] = W'(y);
            endcase
        end
        return r;
    endfunction

    // Monitor: handshakes observed mid-cycle are the ones that fire on the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (pix_cnt_o !== exp_cnt) begin
                errors++;
                $display("FAIL pix_cnt: got %0d expected %0d at %0t", pix_cnt_o, exp_cnt, $time);
            end
            checks++;
            if (ready_o !== (occ < 2 || ready_i)) begin
                errors++;
                $display("FAIL ready_o: got %b expected %b (occ %0d) at %0t",
                         ready_o, (occ < 2 || ready_i), occ, $time);
            end
            if (hold_chk) begin
                checks++;
                if (valid_o !== 1'b1 || pix_o !== hold_pix) begin
                    errors++;
                    $display("FAIL hold: got valid %b pix %h expected valid 1 pix %h at %0t",
                             valid_o, pix_o, hold_pix, $time);
                end
            end
            if (!rst_n) begin
                occ      = 0;
                exp_cnt  = '0;
                hold_chk = 1'b0;
            end else begin
                if (valid_o && ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out: got %h with empty queue at %0t", pix_o, $time);
                    end else begin
                        logic [PW-1:0] e;
                        e = exp_q.pop_front();
                        if (pix_o !== e) begin
                            errors++;
                            $display("FAIL out_pix: got %h expected %h at %0t", pix_o, e, $time);
                        end
                    end
                end
                occ = occ + int'(valid_i && ready_o) - int'(valid_o && ready_i);
                exp_cnt = cnt_clr_i ? '0 : exp_cnt + CNT_W'(valid_o && ready_i);
                hold_chk = valid_o && !ready_i;
                hold_pix = pix_o;
            end
        end
    end

    // Driver: called just after a rising edge; returns just after the accepting edge.
    task automatic send_pix(input logic [PW-1:0] p, input logic [1:0] m,
                            input logic [W-1:0] t, input logic [PW-1:0] e);
        int n = 0;
        valid_i = 1'b1;
        pix_i   = p;
        mode_i  = m;
        thr_i   = t;
        @(negedge clk);
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ready_o) begin
            errors++;
            $display("FAIL send_timeout: ready_o %b expected 1", ready_o);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_cnt();
        cnt_clr_i = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; cnt_clr_i = 1'b0;
        pix_i = '0; mode_i = 2'd0; thr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        checks++;
        if (valid_o !== 1'b0 || pix_o !== '0 || ready_o !== 1'b1 || pix_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid %b pix %h ready %b cnt %0d expected 0 0 1 0",
                     valid_o, pix_o, ready_o, pix_cnt_o);
        end
        send_pix(24'h0080FF, 2'd1, 8'h00, 24'hFF7F00);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid_o %b expected 0", valid_o);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b1 || pix_o !== 24'hFF7F00) begin
            errors++;
            $display("FAIL inv_latency: got valid %b pix %h expected 1 ff7f00", valid_o, pix_o);
        end
        @(posedge clk); #1;
        checks++;
        if (pix_cnt_o !== CNT_W'(1)) begin
            errors++;
            $display("FAIL first_count: got %0d expected 1", pix_cnt_o);
        end
    endtask

    task automatic test_modes();
        ready_i = 1'b1;
        send_pix(24'h102030, 2'd0, 8'h00, 24'h102030);
        send_pix(24'h7F80FF, 2'd2, 8'h80, 24'h00FFFF);
        send_pix(24'h000000, 2'd2, 8'h00, 24'hFFFFFF);
        send_pix(24'hFFFFFF, 2'd3, 8'h00, 24'hFFFFFF);
        send_pix(24'h004080, 2'd3, 8'h00, model_pix(24'h004080, 2'd3, 8'h00));
        send_pix(24'h123456, 2'd1, 8'h00, 24'hEDCBA9);
        drain();
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        bit drv_done = 1'b0;
        bit saw_stall = 1'b0;
        clear_cnt();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [PW-1:0] p;
                    logic [1:0]    m;
                    logic [W-1:0]  t;
                    p = PW'($urandom);
                    m = 2'($urandom_range(0, 3));
                    t = W'($urandom_range(0, 255));
                    send_pix(p, m, t, model_pix(p, m, t));
                end
                drv_done = 1'b1;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    ready_i = pat[i % 4];
                    @(posedge clk); #1;
                    if (!ready_o) saw_stall = 1'b1;
                    if (drv_done && exp_q.size() == 0) break;
                end
            end
        join
        ready_i = 1'b1;
        drain();
        checks++;
        if (!saw_stall) begin
            errors++;
            $display("FAIL bp_stall: ready_o never low, expected low when full");
        end
        checks++;
        if (pix_cnt_o !== CNT_W'(10)) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 10", pix_cnt_o);
        end
    endtask

    task automatic test_counter();
        ready_i = 1'b1;
        clear_cnt();
        for (int i = 0; i < 17; i++) begin
            send_pix(PW'(i), 2'd0, 8'h00, PW'(i));
        end
        drain();
        checks++;
        if (pix_cnt_o !== CNT_W'(1)) begin
            errors++;
            $display("FAIL cnt_wrap: got %0d expected 1", pix_cnt_o);
        end
        send_pix(24'hABCDEF, 2'd0, 8'h00, 24'hABCDEF);
        @(posedge clk); #1;
        cnt_clr_i = 1'b1;
        @(posedge clk); #1;
        cnt_clr_i = 1'b0;
        checks++;
        if (pix_cnt_o !== '0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL cnt_clr_xfer: got cnt %0d valid %b expected 0 0", pix_cnt_o, valid_o);
        end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        send_pix(24'h111111, 2'd0, 8'h00, 24'h111111);
        send_pix(24'h222222, 2'd0, 8'h00, 24'h222222);
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b expected 0", ready_o);
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || pix_cnt_o !== '0) begin
            errors++;
            $display("FAIL mid_reset: got valid %b ready %b cnt %0d expected 0 1 0",
                     valid_o, ready_o, pix_cnt_o);
        end
        ready_i = 1'b1;
        send_pix(24'h0A0B0C, 2'd1, 8'h00, 24'hF5F4F3);
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b1 || pix_o !== 24'hF5F4F3) begin
            errors++;
            $display("FAIL post_reset_pix: got valid %b pix %h expected 1 f5f4f3", valid_o, pix_o);
        end
        drain();
    endtask

    task automatic test_mode_switch();
        ready_i = 1'b1;
        send_pix(24'h0F0F0F, 2'd1, 8'h00, 24'hF0F0F0);
        send_pix(24'h0F0F0F, 2'd0, 8'h00, 24'h0F0F0F);
        drain();
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_counter();
        test_reset_mid();
        test_mode_switch();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
